// File: rtl/ro_puf_counter.sv
// ro_puf_counter
// Ring-oscillator PUF measurement engine. Enables two rings, waits for them
// to settle, counts the rising edges of each over a fixed window, then
// compares the two counts to produce one PUF response bit.
//
// Ports:
//   clk        - system clock, everything on its rising edge
//   reset      - synchronous, active-high reset
//   start      - one-cycle measurement request, honoured only in IDLE
//   challenge  - ring select vector, latched when start is accepted
//   ro_a/ro_b  - asynchronous ring oscillator outputs
//   ro_en      - enable to both rings, high during SETTLE and COUNT
//   sel        - latched challenge, driven to the ring LUT selects
//   busy       - high from the accepted start until done
//   done       - one-cycle pulse when response/tie/counts are valid
//   response   - 1 when count_a > count_b
//   tie        - 1 when count_a == count_b
//   count_a/b  - final saturating edge counts of each ring

module ro_puf_counter #(
  parameter int N_STAGES   = 8,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 16,
  parameter int WINDOW_CYC = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [N_STAGES-1:0] challenge,
  input  logic                ro_a,
  input  logic                ro_b,
  output logic                ro_en,
  output logic [N_STAGES-1:0] sel,
  output logic                busy,
  output logic                done,
  output logic                response,
  output logic                tie,
  output logic [CNT_W-1:0]    count_a,
  output logic [CNT_W-1:0]    count_b
);

  // The timer must reach the last cycle of the longer phase, plus one spare
  // value so the increment in the final COUNT cycle cannot overflow.
  localparam int TIMER_MAX = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYC - 1);
  localparam logic [TIMER_W-1:0] WINDOW_LAST = TIMER_W'(WINDOW_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_COUNT,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [TIMER_W-1:0] timer;

  logic a_meta, a_sync, a_prev;
  logic b_meta, b_sync, b_prev;
  logic edge_a, edge_b;

  // Two-flop synchronizers for the asynchronous ring outputs, followed by one
  // extra registered sample used to detect rising edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_meta <= 1'b0;
      a_sync <= 1'b0;
      a_prev <= 1'b0;
      b_meta <= 1'b0;
      b_sync <= 1'b0;
      b_prev <= 1'b0;
    end else begin
      a_meta <= ro_a;
      a_sync <= a_meta;
      a_prev <= a_sync;
      b_meta <= ro_b;
      b_sync <= b_meta;
      b_prev <= b_sync;
    end
  end

  assign edge_a = a_sync & ~a_prev;
  assign edge_b = b_sync & ~b_prev;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. start is only looked at in IDLE, so a stray pulse
  // during a measurement has no effect.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (start) next_state = S_SETTLE;
      S_SETTLE:  if (timer == SETTLE_LAST) next_state = S_COUNT;
      S_COUNT:   if (timer == WINDOW_LAST) next_state = S_COMPARE;
      S_COMPARE: next_state = S_DONE;
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Control outputs decode straight from the state, so ro_en falls in the
  // very cycle the FSM enters COMPARE.
  always_comb begin
    ro_en = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      S_SETTLE, S_COUNT: begin
        ro_en = 1'b1;
        busy  = 1'b1;
      end
      S_COMPARE: busy = 1'b1;
      S_DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: challenge latch, phase timer, saturating counters and the
  // registered comparison. Results stay untouched outside the active phases
  // so they hold from done until the next accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel      <= '0;
      timer    <= '0;
      count_a  <= '0;
      count_b  <= '0;
      response <= 1'b0;
      tie      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sel      <= challenge;
            timer    <= '0;
            count_a  <= '0;
            count_b  <= '0;
            response <= 1'b0;
            tie      <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (timer == SETTLE_LAST) begin
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_COUNT: begin
          timer <= timer + 1'b1;
          if (edge_a && (count_a != {CNT_W{1'b1}})) begin
            count_a <= count_a + 1'b1;
          end
          if (edge_b && (count_b != {CNT_W{1'b1}})) begin
            count_b <= count_b + 1'b1;
          end
        end
        S_COMPARE: begin
          timer    <= '0;
          response <= (count_a > count_b);
          tie      <= (count_a == count_b);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_puf_counter.sv
// tb_ro_puf_counter
// Self-checking bench for ro_puf_counter. Two instances share all inputs:
// the default 16-bit counter build and an 8-bit counter build used for the
// saturation case. Rings are modelled as free-running square waves whose
// half period is set per test.

module tb_ro_puf_counter;

  localparam int SETTLE = 16;
  localparam int WINDOW = 4096;
  localparam int LAT    = SETTLE + WINDOW + 2;

  typedef struct {
    logic [7:0] challenge;
    int         half_a;
    int         half_b;
    bit         follow;
    int         ca_lo;
    int         ca_hi;
    int         cb_lo;
    int         cb_hi;
    bit         resp;
    bit         tie;
    bit         use8;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] challenge;
  logic       ro_a_gen = 1'b0;
  logic       ro_b_gen = 1'b0;
  logic       b_follow = 1'b0;
  logic       ro_a;
  logic       ro_b;
  int         half_a = 0;
  int         half_b = 0;

  logic        ro_en, busy, done, response, tie;
  logic [7:0]  sel;
  logic [15:0] count_a, count_b;
  logic        ro_en8, busy8, done8, response8, tie8;
  logic [7:0]  sel8;
  logic [7:0]  count_a8, count_b8;

  int   checks = 0;
  int   errors = 0;
  vec_t sb[$];
  vec_t vecs[4];

  assign ro_a = ro_a_gen;
  assign ro_b = b_follow ? ro_a_gen : ro_b_gen;

  // 10-unit clock; rising edges land at 5 mod 10, rings only move on
  // multiples of 10, so the synchronizers never see a coincident edge.
  always #5 clk = ~clk;

  // Ring A model: square wave with half period half_a, held low when zero.
  always begin
    if (half_a == 0) begin
      ro_a_gen = 1'b0;
      #10;
    end else begin
      #(half_a);
      ro_a_gen = ~ro_a_gen;
    end
  end

  // Ring B model, same scheme with half_b.
  always begin
    if (half_b == 0) begin
      ro_b_gen = 1'b0;
      #10;
    end else begin
      #(half_b);
      ro_b_gen = ~ro_b_gen;
    end
  end

  ro_puf_counter #(
    .N_STAGES(8), .CNT_W(16), .SETTLE_CYC(SETTLE), .WINDOW_CYC(WINDOW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .challenge(challenge),
    .ro_a(ro_a), .ro_b(ro_b), .ro_en(ro_en), .sel(sel), .busy(busy),
    .done(done), .response(response), .tie(tie),
    .count_a(count_a), .count_b(count_b)
  );

  ro_puf_counter #(
    .N_STAGES(8), .CNT_W(8), .SETTLE_CYC(SETTLE), .WINDOW_CYC(WINDOW)
  ) dut8 (
    .clk(clk), .reset(reset), .start(start), .challenge(challenge),
    .ro_a(ro_a), .ro_b(ro_b), .ro_en(ro_en8), .sel(sel8), .busy(busy8),
    .done(done8), .response(response8), .tie(tie8),
    .count_a(count_a8), .count_b(count_b8)
  );

  // Range comparison; lo == hi gives an exact match.
  task automatic check(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Compare result outputs of the selected instance against a vector.
  task automatic checkOutput(input vec_t v, input string tag);
    if (v.use8) begin
      check({tag, "_count_a8"}, int'(count_a8), v.ca_lo, v.ca_hi);
      check({tag, "_count_b8"}, int'(count_b8), v.cb_lo, v.cb_hi);
      check({tag, "_response8"}, int'(response8), int'(v.resp), int'(v.resp));
      check({tag, "_tie8"}, int'(tie8), int'(v.tie), int'(v.tie));
    end else begin
      check({tag, "_count_a"}, int'(count_a), v.ca_lo, v.ca_hi);
      check({tag, "_count_b"}, int'(count_b), v.cb_lo, v.cb_hi);
      check({tag, "_response"}, int'(response), int'(v.resp), int'(v.resp));
      check({tag, "_tie"}, int'(tie), int'(v.tie), int'(v.tie));
    end
    check({tag, "_sel"}, int'(sel), int'(v.challenge), int'(v.challenge));
  endtask

  // Program the rings, let them run long enough to flush any old half
  // period, then raise start and record the expected result.
  task automatic applyStimulus(input vec_t v);
    half_a    = v.half_a;
    half_b    = v.half_b;
    b_follow  = v.follow;
    challenge = v.challenge;
    repeat (40) @(posedge clk);
    #1;
    start = 1'b1;
    sb.push_back(v);
  endtask

  // Follow one measurement to its done pulse. Cycle 1 is the edge that
  // accepts start; done is expected at cycle LAT. repulse_at > 0 raises
  // start again for one cycle at that point to prove it is ignored.
  task automatic runToDone(input int repulse_at, input logic [7:0] exp_sel);
    int   cyc;
    bit   seen;
    vec_t v;
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < LAT + 50) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        check("busy_after_start", int'(busy), 1, 1);
        check("ro_en_after_start", int'(ro_en), 1, 1);
      end
      if (repulse_at > 0 && cyc == repulse_at) start = 1'b1;
      if (repulse_at > 0 && cyc == repulse_at + 1) start = 1'b0;
      if (cyc == SETTLE + 5) check("sel_mid_run", int'(sel), int'(exp_sel), int'(exp_sel));
      if (cyc == LAT - 1) begin
        check("ro_en_in_compare", int'(ro_en), 0, 0);
        check("busy_in_compare", int'(busy), 1, 1);
      end
      if (done) seen = 1;
    end
    if (!seen) begin
      check("done_timeout", 0, 1, 1);
      sb.delete();
      return;
    end
    check("latency", cyc, LAT, LAT);
    check("busy_at_done", int'(busy), 0, 0);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1, 1);
      return;
    end
    v = sb.pop_front();
    checkOutput(v, "result");
    repeat (5) @(posedge clk);
    #1;
    check("done_single_pulse", int'(done), 0, 0);
    checkOutput(v, "hold");
  endtask

  initial begin
    vec_t v;
    int   cyc;
    int   done_seen;

    vecs[0] = '{8'hA5, 40, 50,  1'b0, 512, 512, 409, 411, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 40, 40,  1'b1, 512, 512, 512, 512, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h5A, 20, 320, 1'b0, 255, 255, 64,  64,  1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'hC3, 0,  0,   1'b0, 0,   0,   0,   0,   1'b0, 1'b1, 1'b0};

    reset     = 1'b1;
    start     = 1'b0;
    challenge = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ro_en", int'(ro_en), 0, 0);
    check("rst_busy", int'(busy), 0, 0);
    check("rst_done", int'(done), 0, 0);
    check("rst_sel", int'(sel), 0, 0);
    check("rst_count_a", int'(count_a), 0, 0);
    check("rst_count_b", int'(count_b), 0, 0);
    check("rst_response", int'(response), 0, 0);
    check("rst_tie", int'(tie), 0, 0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i]);
      runToDone(0, vecs[i].challenge);
    end

    // start re-pulsed 100 cycles into COUNT must not disturb anything.
    v = '{8'h11, 40, 80, 1'b0, 512, 512, 256, 256, 1'b1, 1'b0, 1'b0};
    applyStimulus(v);
    runToDone(1 + SETTLE + 100, 8'h11);

    // Reset 2000 cycles into COUNT aborts without a done pulse.
    v = '{8'h77, 40, 50, 1'b0, 512, 512, 409, 411, 1'b1, 1'b0, 1'b0};
    applyStimulus(v);
    void'(sb.pop_back());
    done_seen = 0;
    for (cyc = 1; cyc <= SETTLE + 2000; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) start = 1'b0;
      if (done) done_seen++;
    end
    check("count_a_before_abort", int'(count_a), 200, 300);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ro_en", int'(ro_en), 0, 0);
    check("abort_busy", int'(busy), 0, 0);
    check("abort_count_a", int'(count_a), 0, 0);
    check("abort_count_b", int'(count_b), 0, 0);
    check("abort_sel", int'(sel), 0, 0);
    reset = 1'b0;
    for (int k = 0; k < 2300; k++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 0, 0);

    applyStimulus(vecs[0]);
    runToDone(0, vecs[0].challenge);

    // reset wins over start in the same cycle.
    reset     = 1'b1;
    start     = 1'b1;
    challenge = 8'hEE;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    check("reset_priority_busy", int'(busy), 0, 0);
    check("reset_priority_sel", int'(sel), 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_priority_idle", int'(busy), 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
